// File: rtl/dice_roll_engine.sv
// dice_roll_engine
//
// Dice-side responder to the game FSM. On an accepted roll trigger every
// non-held die spins for SPIN_CYCLES cycles, loading a face derived from a
// free-running 16-bit Galois LFSR. A one-cycle roll_done pulse follows the
// final update. First-roll triggers with any hold switch set are rejected
// with a hold_err pulse; triggers with roll_cnt==3 are rejected silently.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   roll_trigger  in   one-cycle roll request
//   dice_clear    in   clear all dice and return to idle
//   hold_sw[4:0]  in   per-die hold request
//   roll_cnt[1:0] in   rolls already counted this turn
//   dice_vals     out  die i at [3i+2:3i], 0 = blank, 1..6 = face
//   hold_eff      out  hold mask latched at accept
//   busy          out  high while spinning
//   roll_done     out  one-cycle pulse when faces are final
//   hold_err      out  one-cycle pulse on a rejected first-roll hold
//   dice_sum      out  sum of the five faces

module dice_roll_engine #(
    parameter int unsigned SPIN_CYCLES = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        roll_trigger,
    input  logic        dice_clear,
    input  logic [4:0]  hold_sw,
    input  logic [1:0]  roll_cnt,
    output logic [14:0] dice_vals,
    output logic [4:0]  hold_eff,
    output logic        busy,
    output logic        roll_done,
    output logic        hold_err,
    output logic [4:0]  dice_sum
);

    typedef enum logic [1:0] {StIdle, StSpin, StDone} state_e;

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  CntLoad = 8'(SPIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [14:0] dice_q, dice_d;
    logic [4:0]  hold_q, hold_d;
    logic        roll_done_q, roll_done_d;
    logic        hold_err_q, hold_err_d;
    logic [14:0] spin_dice;

    // Folds a 3-bit value 0..7 onto 1..6.
    function automatic logic [2:0] face_map(input logic [2:0] c);
        return (c < 3'd6) ? (c + 3'd1) : (c - 3'd5);
    endfunction

    // Candidate dice for a spin cycle; a held blank die still spins.
    always_comb begin
        spin_dice = dice_q;
        for (int i = 0; i < 5; i++) begin
            if (!(hold_q[i] && (dice_q[3*i +: 3] != 3'd0))) begin
                spin_dice[3*i +: 3] = face_map(lfsr_q[3*i +: 3]);
            end
        end
    end

    always_comb begin
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        state_d     = state_q;
        cnt_d       = cnt_q;
        dice_d      = dice_q;
        hold_d      = hold_q;
        hold_err_d  = 1'b0;
        roll_done_d = (state_q == StDone);

        if (dice_clear) begin
            state_d     = StIdle;
            cnt_d       = 8'd0;
            dice_d      = 15'd0;
            hold_d      = 5'd0;
            roll_done_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (roll_trigger) begin
                        if ((roll_cnt == 2'd0) && (|hold_sw)) begin
                            hold_err_d = 1'b1;
                        end else if (roll_cnt != 2'd3) begin
                            hold_d  = (roll_cnt == 2'd0) ? 5'd0 : hold_sw;
                            cnt_d   = CntLoad;
                            state_d = StSpin;
                        end
                    end
                end
                StSpin: begin
                    dice_d = spin_dice;
                    if (cnt_q == 8'd0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            lfsr_q      <= SeedEff;
            cnt_q       <= 8'd0;
            dice_q      <= 15'd0;
            hold_q      <= 5'd0;
            roll_done_q <= 1'b0;
            hold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            dice_q      <= dice_d;
            hold_q      <= hold_d;
            roll_done_q <= roll_done_d;
            hold_err_q  <= hold_err_d;
        end
    end

    assign dice_vals = dice_q;
    assign hold_eff  = hold_q;
    assign busy      = (state_q == StSpin);
    assign roll_done = roll_done_q;
    assign hold_err  = hold_err_q;
    assign dice_sum  = {2'b00, dice_q[2:0]}   + {2'b00, dice_q[5:3]} +
                       {2'b00, dice_q[8:6]}   + {2'b00, dice_q[11:9]} +
                       {2'b00, dice_q[14:12]};

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed self-checking bench for dice_roll_engine.
module tb_dice_roll_engine;

    localparam logic [15:0] Seed = 16'hACE1;

    logic        clk;
    logic        reset;
    logic        roll_trigger;
    logic        dice_clear;
    logic [4:0]  hold_sw;
    logic [1:0]  roll_cnt;
    logic [14:0] dice_vals;
    logic [4:0]  hold_eff;
    logic        busy;
    logic        roll_done;
    logic        hold_err;
    logic [4:0]  dice_sum;

    int n_checks = 0;
    int n_fail   = 0;

    dice_roll_engine #(
        .SPIN_CYCLES(8),
        .LFSR_SEED  (Seed)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .roll_trigger(roll_trigger),
        .dice_clear  (dice_clear),
        .hold_sw     (hold_sw),
        .roll_cnt    (roll_cnt),
        .dice_vals   (dice_vals),
        .hold_eff    (hold_eff),
        .busy        (busy),
        .roll_done   (roll_done),
        .hold_err    (hold_err),
        .dice_sum    (dice_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR; m_prev holds the value the DUT sampled at the last edge.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr <= Seed;
            m_prev <= 16'h0000;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] spin_model(input logic [15:0] l, input logic [4:0] h,
                                               input logic [14:0] cur);
        logic [14:0] r;
        logic [2:0]  c;
        r = cur;
        for (int i = 0; i < 5; i++) begin
            c = l[3*i +: 3];
            if (!(h[i] && cur[3*i +: 3] != 3'd0)) begin
                r[3*i +: 3] = (c < 3'd6) ? c + 3'd1 : c - 3'd5;
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] sum_model(input logic [14:0] d);
        logic [4:0] s;
        s = 5'd0;
        for (int i = 0; i < 5; i++) s = s + {2'b00, d[3*i +: 3]};
        return s;
    endfunction

    // Full accepted roll with per-cycle checks; cur = bench's idea of dice beforehand.
    task automatic run_roll(input logic [1:0] rc, input logic [4:0] hs, input string tag,
                            input logic [14:0] cur, output logic [14:0] faces);
        logic [4:0]  exp_hold;
        logic [14:0] exp_d;
        exp_hold     = (rc == 2'd0) ? 5'd0 : hs;
        exp_d        = cur;
        roll_cnt     = rc;
        hold_sw      = hs;
        roll_trigger = 1'b1;
        step();
        roll_trigger = 1'b0;
        check_eq({tag, "_busy_e0"}, 32'(busy), 32'd1);
        check_eq({tag, "_hold_eff"}, 32'(hold_eff), 32'(exp_hold));
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_d = spin_model(m_prev, exp_hold, exp_d);
            check_eq($sformatf("%s_dice_e%0d", tag, k), 32'(dice_vals), 32'(exp_d));
            check_eq($sformatf("%s_busy_e%0d", tag, k), 32'(busy), (k < 8) ? 32'd1 : 32'd0);
        end
        check_eq({tag, "_done_early"}, 32'(roll_done), 32'd0);
        step();
        check_eq({tag, "_done"}, 32'(roll_done), 32'd1);
        check_eq({tag, "_sum"}, 32'(dice_sum), 32'(sum_model(exp_d)));
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("%s_range%0d", tag, i),
                     32'(dice_vals[3*i +: 3] >= 3'd1 && dice_vals[3*i +: 3] <= 3'd6), 32'd1);
        end
        step();
        check_eq({tag, "_done_drop"}, 32'(roll_done), 32'd0);
        faces = exp_d;
    endtask

    // Reset, clear pulse, then a first roll; timing is identical on every call.
    task automatic first_roll(input string tag, output logic [14:0] faces);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        dice_clear = 1'b1;
        step();
        dice_clear = 1'b0;
        run_roll(2'd0, 5'd0, tag, 15'd0, faces);
    endtask

    logic [14:0] f1, f2, f3, f_tmp, saved;
    int          n_done, done_at, n_busy;

    initial begin
        reset        = 1'b1;
        roll_trigger = 1'b0;
        dice_clear   = 1'b0;
        hold_sw      = 5'd0;
        roll_cnt     = 2'd0;
        #12;
        check_eq("rst_dice", 32'(dice_vals), 32'd0);
        check_eq("rst_hold", 32'(hold_eff), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(roll_done), 32'd0);
        check_eq("rst_err", 32'(hold_err), 32'd0);
        check_eq("rst_sum", 32'(dice_sum), 32'd0);

        // Roll 1 and roll 2 with holds on dice 0, 2, 4.
        first_roll("r1", f1);
        run_roll(2'd1, 5'b10101, "r2", f1, f2);
        check_eq("r2_keep0", 32'(f2[2:0]), 32'(f1[2:0]));
        check_eq("r2_keep4", 32'(f2[14:12]), 32'(f1[14:12]));

        // Illegal first-roll hold.
        roll_cnt     = 2'd0;
        hold_sw      = 5'b00001;
        roll_trigger = 1'b1;
        step();
        roll_trigger = 1'b0;
        check_eq("herr_pulse", 32'(hold_err), 32'd1);
        check_eq("herr_busy", 32'(busy), 32'd0);
        check_eq("herr_dice", 32'(dice_vals), 32'(f2));
        step();
        check_eq("herr_drop", 32'(hold_err), 32'd0);
        check_eq("herr_nodone", 32'(roll_done), 32'd0);
        check_eq("herr_busy2", 32'(busy), 32'd0);

        // Re-trigger during spin is ignored.
        roll_cnt     = 2'd1;
        hold_sw      = 5'd0;
        roll_trigger = 1'b1;
        step();
        roll_trigger = 1'b0;
        n_done  = 0;
        done_at = -1;
        for (int s = 1; s <= 14; s++) begin
            if (s == 3) roll_trigger = 1'b1;
            step();
            roll_trigger = 1'b0;
            if (roll_done) begin
                n_done++;
                done_at = s;
            end
        end
        check_eq("retrig_count", 32'(n_done), 32'd1);
        check_eq("retrig_at", 32'(done_at), 32'd9);

        // roll_cnt==3: no response at all.
        saved        = dice_vals;
        roll_cnt     = 2'd3;
        roll_trigger = 1'b1;
        step();
        roll_trigger = 1'b0;
        check_eq("rc3_busy", 32'(busy), 32'd0);
        check_eq("rc3_err", 32'(hold_err), 32'd0);
        n_done = 0;
        n_busy = 0;
        for (int s = 0; s < 10; s++) begin
            step();
            if (roll_done) n_done++;
            if (busy) n_busy++;
        end
        check_eq("rc3_nodone", 32'(n_done), 32'd0);
        check_eq("rc3_nobusy", 32'(n_busy), 32'd0);
        check_eq("rc3_dice", 32'(dice_vals), 32'(saved));

        // Clear in the middle of a spin.
        roll_cnt     = 2'd2;
        hold_sw      = 5'b00011;
        roll_trigger = 1'b1;
        step();
        roll_trigger = 1'b0;
        repeat (3) step();
        check_eq("clr_hold_pre", 32'(hold_eff), 32'h03);
        dice_clear = 1'b1;
        step();
        dice_clear = 1'b0;
        check_eq("clr_dice", 32'(dice_vals), 32'd0);
        check_eq("clr_busy", 32'(busy), 32'd0);
        check_eq("clr_hold", 32'(hold_eff), 32'd0);
        n_done = 0;
        for (int s = 0; s < 12; s++) begin
            step();
            if (roll_done) n_done++;
        end
        check_eq("clr_nodone", 32'(n_done), 32'd0);

        // Clear and trigger together after a fresh roll.
        run_roll(2'd1, 5'd0, "r3", 15'd0, f_tmp);
        roll_cnt     = 2'd1;
        roll_trigger = 1'b1;
        dice_clear   = 1'b1;
        step();
        roll_trigger = 1'b0;
        dice_clear   = 1'b0;
        check_eq("clrtrig_dice", 32'(dice_vals), 32'd0);
        check_eq("clrtrig_busy", 32'(busy), 32'd0);
        step();
        check_eq("clrtrig_busy2", 32'(busy), 32'd0);
        check_eq("clrtrig_nodone", 32'(roll_done), 32'd0);

        // Async reset partway through a spin.
        roll_cnt     = 2'd1;
        roll_trigger = 1'b1;
        step();
        roll_trigger = 1'b0;
        repeat (5) step();
        check_eq("ar_busy_pre", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("ar_dice", 32'(dice_vals), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_hold", 32'(hold_eff), 32'd0);
        check_eq("ar_done", 32'(roll_done), 32'd0);
        check_eq("ar_sum", 32'(dice_sum), 32'd0);
        first_roll("r1b", f3);
        check_eq("ar_repeat", 32'(f3), 32'(f1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
